// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared encodings and lane-mask helper for the data RAM slave
package data_ram_pkg;
    localparam logic [1:0] BE_BYTE = 2'b00;
    localparam logic [1:0] BE_HALF = 2'b01;
    localparam logic [1:0] BE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    // Byte lanes touched by an access; 2'b11 falls through to word.
    function automatic logic [3:0] lane_mask(input logic [1:0] be, input logic [1:0] a);
        return be == BE_BYTE ? 4'b0001 << a : be == BE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: lane steering between right-aligned bus data and 32-bit RAM words
// Ports: be/addr_lo select size and lane; wdata is right-aligned write data;
// rword is the addressed RAM word; mask/wword drive the lane write; rdata is the
// right-aligned zero-extended read value; misalign flags an illegal alignment.
module mem_lane_align
    import data_ram_pkg::*;
(
    input  logic [1:0]  be,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  mask,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);
    always_comb begin
        misalign = be == BE_BYTE ? 1'b0 : be == BE_HALF ? addr_lo[0] : |addr_lo;
        mask     = misalign ? 4'b0000 : lane_mask(be, addr_lo);
        // Replicate so whichever lanes the mask enables already hold the data.
        wword    = be == BE_BYTE ? {4{wdata[7:0]}} : be == BE_HALF ? {2{wdata[15:0]}} : wdata;
        rdata    = misalign ? 32'h0 : (rword >> {addr_lo, 3'b000}) &
                   (be == BE_BYTE ? 32'h0000_00FF : be == BE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    end
endmodule

// File: rtl/data_ram_slave.sv
// data_ram_slave: word-organised on-chip RAM responding to the CPU data port
// Ports: sys_clk/sys_rst (async active-low); stb_in/we_in/be_in/addr_in/data_in
// form the request; ack_out pulses on completion with data_out valid; stall_out
// is high while a request is in flight; misalign_out pulses with ack_out.
module data_ram_slave
    import data_ram_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        stb_in,
    input  logic        we_in,
    input  logic [1:0]  be_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic        ack_out,
    output logic [31:0] data_out,
    output logic        stall_out,
    output logic        misalign_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t          state, next;
    logic [3:0]      cnt;
    logic            req_we;
    logic [1:0]      req_be;
    logic [AW+1:0]   req_addr;
    logic [31:0]     req_data;
    logic [31:0]     mem [DEPTH];
    logic            accept, enter_ack, cur_we, mis;
    logic [1:0]      cur_be;
    logic [AW+1:0]   cur_addr;
    logic [31:0]     cur_data, wword, rdata;
    logic [3:0]      mask;
    logic            unused_addr;

    assign unused_addr = ^addr_in[31:AW+2];

    // With no wait states ACK is entered on the acceptance edge itself, before
    // the request registers are loaded, so the live inputs are used in IDLE.
    assign cur_we   = state == IDLE ? we_in : req_we;
    assign cur_be   = state == IDLE ? be_in : req_be;
    assign cur_addr = state == IDLE ? addr_in[AW+1:0] : req_addr;
    assign cur_data = state == IDLE ? data_in : req_data;

    assign accept       = state == IDLE && stb_in;
    assign enter_ack    = next == ACK && state != ACK;
    assign ack_out      = state == ACK;
    assign stall_out    = state != IDLE;
    assign misalign_out = state == ACK && mis;

    mem_lane_align u_align (
        .be       (cur_be),
        .addr_lo  (cur_addr[1:0]),
        .wdata    (cur_data),
        .rword    (mem[cur_addr[AW+1:2]]),
        .mask     (mask),
        .wword    (wword),
        .rdata    (rdata),
        .misalign (mis)
    );

    always_comb begin
        next = state;
        next = state == IDLE ? (stb_in ? (WAIT_CYCLES > 0 ? WAIT : ACK) : IDLE) :
               state == WAIT ? (cnt == '0 ? ACK : WAIT) : IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_we   <= 1'b0;
            req_be   <= '0;
            req_addr <= '0;
            req_data <= '0;
            data_out <= '0;
        end else begin
            state <= next;
            if (accept) begin
                cnt      <= CNT_INIT;
                req_we   <= we_in;
                req_be   <= be_in;
                req_addr <= addr_in[AW+1:0];
                req_data <= data_in;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_ack && !cur_we) data_out <= rdata;
        end
    end

    // RAM is not reset; the sys_rst gate keeps a request seen during reset from writing.
    always_ff @(posedge sys_clk) begin
        if (enter_ack && cur_we && sys_rst)
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
    end

    a_stb_known: assert property (@(posedge sys_clk) disable iff (!sys_rst)
        state == IDLE |-> !$isunknown(stb_in));
endmodule

// File: doc/data_ram_slave.md
Name: data_ram_slave

Overview:
- Bus responder (slave) for the CPU data port: accepts stb/we/be/addr/data requests and returns ack plus read data.
- On-chip word-organised RAM with a configurable number of wait states.
- Sits between the cpu_top data-port outputs and the system.
- Provides a stall output so a future pipelined master can hold off new requests while one is in flight.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of 2; AW = log2(DEPTH).
- WAIT_CYCLES, 0, extra cycles between request acceptance and ack (0..15).

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- stb_in  in  1  request strobe from CPU data port.
- we_in  in  1  1 = write, 0 = read.
- be_in  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- addr_in  in  32  byte address.
- data_in  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- ack_out  out  1  one-cycle completion pulse.
- data_out  out  32  read data, right-aligned, zero-extended; valid only while ack_out=1.
- stall_out  out  1  1 = busy, new stb_in is ignored.
- misalign_out  out  1  one-cycle pulse coincident with ack_out for a misaligned access.

Behaviour:
- Reset (sys_rst=0, async):
  - state=IDLE; ack_out=0, data_out=0, stall_out=0, misalign_out=0; wait counter=0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, ACK.
- IDLE:
  - stb_in=1 at a rising edge accepts the request and latches we, be, addr, data.
  - Next state: WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise ACK.
  - stall_out=0 in IDLE.
- WAIT:
  - Counter decrements each cycle; at 0 the next state is ACK.
  - stall_out=1; stb_in is ignored.
- ACK:
  - ack_out=1 for exactly one cycle; stall_out=1; stb_in is ignored. Next state: IDLE.
  - A request held high by the master is re-sampled only in IDLE; the master must drop stb after ack.
- Latency: ack_out is asserted WAIT_CYCLES+1 cycles after the acceptance edge. Minimum request spacing is WAIT_CYCLES+2 cycles.
- Word index = addr[AW+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Lane and alignment:
  - byte: lane = addr[1:0].
  - half: addr[0] must be 0; lane = addr[1].
  - word: addr[1:0] must be 00.
- Write:
  - Committed on the edge that enters ACK; only the selected lanes change.
  - A read accepted after that ack returns the new data.
- Read:
  - RAM is read on the edge entering ACK. data_out = selected lane shifted to bit 0, upper bits 0.
  - Sign extension is the CPU's job.
- Misaligned access:
  - ack is still produced (the master must never hang) and misalign_out=1 with ack.
  - Writes are suppressed; reads return 32'h0.
- data_out holds its last ack value outside ack cycles. The verifier only checks it during ack.
- Reset mid-operation: the pending request is discarded, no write occurs, and outputs return to reset values immediately.
- X on stb_in in IDLE is treated as an assertion error in simulation.

Decomposition:
- Package data_ram_pkg:
  - be encodings BE_BYTE=2'b00, BE_HALF=2'b01, BE_WORD=2'b10.
  - state encoding IDLE/WAIT/ACK.
  - function computing the 4-bit lane write mask from be and addr[1:0].
- Sub-module mem_lane_align (combinational):
  - Produces the write mask, aligned write word, extracted right-aligned read word, and misalign flag.
- The FSM, counter and RAM array stay in data_ram_slave.

Test Plan:
- WAIT_CYCLES=0: write word 32'hDEADBEEF to 0x10, then read 0x10 -> ack one cycle after each acceptance; read data_out=32'hDEADBEEF.
- Byte writes 8'h11, 8'h22, 8'h33, 8'h44 to 0x20..0x23, then word read of 0x20 -> 32'h44332211. Byte read of 0x22 -> 32'h00000033.
- Half write 16'hA5A5 to 0x32 over word 0, then word read of 0x30 -> 32'hA5A50000. Half read of 0x32 -> 32'h0000A5A5.
- Misaligned word write to 0x41 -> ack=1 and misalign_out=1 in the same cycle. A following word read of 0x40 returns the prior contents unchanged. Misaligned half read of 0x43 -> data_out=0.
- WAIT_CYCLES=3: read accepted at cycle 0 -> ack at cycle 4; stall_out=1 in cycles 1-4. A second stb pulse at cycle 2 produces no extra ack.
- Reset asserted in the WAIT state of a write to 0x50 -> ack never rises and outputs go to 0. After release, a read of 0x50 returns the pre-write value.
- Address wrap with DEPTH=1024: write to 0x1000 -> a read of 0x0 returns the same data.
